ones_frame_acc: RTL

Sequential stage downstream of the 15-input ones counter. Accepts one 4-bit per-word ones count per handshake and accumulates FRAME_LEN counts into a frame total. It then presents the total, a saturation flag and a threshold-compare flag to the consumer through a valid/ready handshake. This turns the per-word combinational popcount into a per-frame statistic for density checks.

---
 rtl/ones_frame_acc.sv | 99 +++++++++
 1 files changed

// File: rtl/ones_frame_acc.sv
// Frame accumulator for per-word ones counts: sums FRAME_LEN counts into a
// saturating total and hands it to a consumer over a valid/ready handshake.
module ones_frame_acc #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned SUM_W     = 8,
  parameter int unsigned THRESH    = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cnt_in,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic             sat,
  output logic             over_thresh,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned ADD_W = SUM_W + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] words;
  logic             accept;
  logic             last_word;
  logic [ADD_W-1:0] add_full;
  logic [SUM_W-1:0] sum_nxt;

  // One extra adder bit detects overflow; the total clamps at all-ones.
  assign accept    = cnt_valid & cnt_ready;
  assign last_word = (words == CNT_W'(FRAME_LEN - 1));
  assign add_full  = ADD_W'(sum_out) + ADD_W'(cnt_in);
  assign sum_nxt   = add_full[SUM_W] ? SUM_MAX : add_full[SUM_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && last_word) state_nxt = DONE;
      DONE:    if (sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode state only, never the partner's valid/ready
  always_comb begin
    cnt_ready = 1'b0;
    sum_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:    busy      = 1'b0;
      ACCUM:   cnt_ready = 1'b1;
      DONE:    sum_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Frame datapath; results are frozen in DONE because nothing is accepted there
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out     <= '0;
      sat         <= 1'b0;
      over_thresh <= 1'b0;
      words       <= '0;
    end else if (state == IDLE && start) begin
      sum_out     <= '0;
      sat         <= 1'b0;
      over_thresh <= 1'b0;
      words       <= '0;
    end else if (accept) begin
      sum_out     <= sum_nxt;
      sat         <= sat | add_full[SUM_W];
      over_thresh <= (sum_nxt >= SUM_W'(THRESH));
      words       <= words + CNT_W'(1);
    end
  end

endmodule
